// File: rtl/hps_cmd_decoder_if.sv
// HPS user-IO word bus between the HPS bridge (master) and the command decoder (slave).
interface hps_cmd_decoder_if;
  logic        io_uio;
  logic        io_strobe;
  logic [15:0] io_din;
  logic [15:0] io_dout;

  modport master (output io_uio, io_strobe, io_din, input io_dout);
  modport slave  (input io_uio, io_strobe, io_din, output io_dout);
endinterface

// File: rtl/hps_cmd_decoder.sv
// HPS user-IO command decoder: cfg/status/joystick registers, core ID read-back and
// optional PS/2 keyboard byte FIFO (enabled by defining HPS_CMD_PS2_EN).
module hps_cmd_decoder #(
  parameter logic [15:0] CORE_ID = 16'h00A4
) (
  input  logic                     clk_sys,
  input  logic                     reset_n,
  hps_cmd_decoder_if.slave         hps,
  output logic [15:0]              cfg,
  output logic                     cfg_ready,
  output logic [31:0]              status,
  output logic                     status_set,
  output logic [15:0]              joy0,
  output logic [15:0]              joy1,
  output logic [7:0]               kbd_data,
  output logic                     kbd_valid,
  input  logic                     kbd_rd,
  output logic                     kbd_ovf
);

  typedef enum logic [1:0] {ST_IDLE, ST_IDX1, ST_IDX2, ST_IDX3} state_t;

  localparam logic [7:0] CMD_ID     = 8'h00;
  localparam logic [7:0] CMD_CFG    = 8'h01;
  localparam logic [7:0] CMD_JOY0   = 8'h02;
  localparam logic [7:0] CMD_JOY1   = 8'h03;
  localparam logic [7:0] CMD_STATUS = 8'h1E;
`ifdef HPS_CMD_PS2_EN
  localparam logic [7:0] CMD_KBD    = 8'h05;
`endif

  state_t      state, state_nx;
  logic        strobe_q;
  logic        edge_q;
  logic [15:0] din_q;
  logic [7:0]  cmd_q;
  logic [15:0] shadow_q;
  logic [15:0] dout_q;

  logic        word_ok;
  logic        cmd_ld;
  logic        cfg_we;
  logic        joy0_we;
  logic        joy1_we;
  logic        shadow_we;
  logic        status_we;
  logic        kbd_push;

  // Edge is registered together with its word; all register writes happen one clock later.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      strobe_q <= 1'b0;
      edge_q   <= 1'b0;
      din_q    <= '0;
    end else begin
      strobe_q <= hps.io_strobe;
      edge_q   <= hps.io_strobe & ~strobe_q & hps.io_uio;
      din_q    <= hps.io_din;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (!hps.io_uio) begin
      state_nx = ST_IDLE;
    end else if (edge_q) begin
      case (state)
        ST_IDLE: state_nx = ST_IDX1;
        ST_IDX1: state_nx = ST_IDX2;
        ST_IDX2: state_nx = ST_IDX3;
        default: state_nx = ST_IDX3;
      endcase
    end
  end

  always_comb begin
    word_ok   = hps.io_uio & edge_q;
    cmd_ld    = 1'b0;
    cfg_we    = 1'b0;
    joy0_we   = 1'b0;
    joy1_we   = 1'b0;
    shadow_we = 1'b0;
    status_we = 1'b0;
    kbd_push  = 1'b0;
    if (word_ok && state == ST_IDLE) begin
      cmd_ld = 1'b1;
    end else if (word_ok) begin
      case (cmd_q)
        CMD_CFG:    cfg_we  = (state == ST_IDX1);
        CMD_JOY0:   joy0_we = (state == ST_IDX1);
        CMD_JOY1:   joy1_we = (state == ST_IDX1);
        CMD_STATUS: begin
          shadow_we = (state == ST_IDX1);
          status_we = (state == ST_IDX2);
        end
`ifdef HPS_CMD_PS2_EN
        CMD_KBD:    kbd_push = 1'b1;
`endif
        default: ;
      endcase
    end
  end

  // The status low-half shadow deliberately survives io_uio going low.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cmd_q      <= CMD_ID;
      dout_q     <= '0;
      cfg        <= '0;
      cfg_ready  <= 1'b0;
      shadow_q   <= '0;
      status     <= '0;
      status_set <= 1'b0;
      joy0       <= '0;
      joy1       <= '0;
    end else begin
      status_set <= status_we;
      if (!hps.io_uio) begin
        cmd_q  <= CMD_ID;
        dout_q <= '0;
      end else if (cmd_ld) begin
        cmd_q  <= din_q[7:0];
        dout_q <= (din_q[7:0] == CMD_ID) ? CORE_ID : '0;
      end
      if (cfg_we) begin
        cfg       <= din_q;
        cfg_ready <= 1'b1;
      end
      if (shadow_we) shadow_q <= din_q;
      if (status_we) status   <= {din_q, shadow_q};
      if (joy0_we)   joy0     <= din_q;
      if (joy1_we)   joy1     <= din_q;
    end
  end

  assign hps.io_dout = dout_q;

`ifdef HPS_CMD_PS2_EN
  logic [7:0] fifo_mem [4];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic [2:0] fifo_cnt;
  logic       fifo_pop;
  logic       fifo_full;
  logic       push_ok;

  // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
  assign fifo_pop  = kbd_rd & (fifo_cnt != 3'd0);
  assign fifo_full = (fifo_cnt == 3'd4);
  assign push_ok   = kbd_push & (~fifo_full | fifo_pop);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < 4; i++) fifo_mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      kbd_ovf  <= 1'b0;
    end else begin
      if (fifo_pop) rd_ptr <= rd_ptr + 2'd1;
      if (push_ok) begin
        fifo_mem[wr_ptr] <= din_q[7:0];
        wr_ptr           <= wr_ptr + 2'd1;
      end
      if (kbd_push && fifo_full && !fifo_pop) kbd_ovf <= 1'b1;
      case ({push_ok, fifo_pop})
        2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  assign kbd_valid = (fifo_cnt != 3'd0);
  assign kbd_data  = kbd_valid ? fifo_mem[rd_ptr] : '0;
`else
  logic unused_kbd;
  assign unused_kbd = kbd_rd | kbd_push;
  assign kbd_valid  = 1'b0;
  assign kbd_data   = '0;
  assign kbd_ovf    = 1'b0;
`endif

endmodule
